// File: rtl/filter_pkg.sv
// filter_pkg: shared defaults and the counter reload helper for multi_filter.
// The reload helper works on a 64-bit value, so CNT_WIDTH may be at most 64.
package filter_pkg;

  localparam int DEF_CHANNELS    = 8;
  localparam int DEF_CNT_WIDTH   = 32;
  localparam int DEF_SYNC_STAGES = 2;

  // Widest count the reload helper accepts; channels truncate back to CNT_WIDTH.
  localparam int MAX_CNT_WIDTH   = 64;

  typedef logic [MAX_CNT_WIDTH-1:0] cnt_max_t;

  // Reload value for a stability count: count-1, with 0 saturating to 0 so a
  // zero count behaves exactly like a count of one and never wraps to all-ones.
  function automatic cnt_max_t reload_value(input cnt_max_t filter_cnt);
    cnt_max_t r;
    if (filter_cnt == '0) begin
      r = '0;
    end else begin
      r = filter_cnt - cnt_max_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/filter_chan.sv
// filter_chan: one debounce channel. Synchroniser chain, one-cycle delayed
// copy d of the synchronised level, a stability down-counter and the
// registered filtered level with rise/fall pulses.
module filter_chan
  import filter_pkg::*;
#(
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_raw,
  input  logic [CNT_WIDTH-1:0] filter_cnt,
  input  logic                 en,
  output logic                 out,
  output logic                 rise,
  output logic                 fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   d_q, d_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  logic                   s;
  logic [CNT_WIDTH-1:0]   reload;

  assign s      = sync_q[SYNC_STAGES-1];
  assign reload = CNT_WIDTH'(reload_value(cnt_max_t'(filter_cnt)));

  // Synchroniser shift: stage 0 samples the raw pin, later stages follow.
  always_comb begin
    sync_d[0] = in_raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Stability counter, filtered level and edge pulses for the next cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
    d_d    = s;
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;

    if (!en) begin
      // Frozen: keep the counter armed so re-enable waits a full stable count.
      cnt_d = reload;
    end else begin
      if (s != d_q) begin
        cnt_d = reload;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
      end

      // An expired counter re-latches d; after a rejected glitch d has
      // returned to the old level, so nothing changes and no pulse fires.
      if (cnt_q == '0) begin
        out_d = d_q;
      end

      rise_d = out_d & ~out_q;
      fall_d = ~out_d & out_q;
    end
  end

  // Channel state registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      sync_q <= '0;
      d_q    <= 1'b0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/multi_filter.sv
// multi_filter: CHANNELS independent glitch filters / debouncers sharing one
// stability count, plus an aggregate change flag.
// Optional build macro FILTER_IRQ_EN adds sticky per-channel event bits with
// write-one-to-clear and a registered interrupt; without it io_evt and io_irq
// are tied low and io_evtClr is ignored.
module multi_filter
  import filter_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 io_clk,
  input  logic                 io_rst,
  input  logic [CHANNELS-1:0]  io_in,
  input  logic [CNT_WIDTH-1:0] io_filterCnt,
  input  logic [CHANNELS-1:0]  io_chEn,
  output logic [CHANNELS-1:0]  io_out,
  output logic [CHANNELS-1:0]  io_rise,
  output logic [CHANNELS-1:0]  io_fall,
  output logic                 io_changed,
  input  logic [CHANNELS-1:0]  io_evtClr,
  output logic [CHANNELS-1:0]  io_evt,
  output logic                 io_irq
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    filter_chan #(
      .CNT_WIDTH   (CNT_WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk        (io_clk),
      .rst        (io_rst),
      .in_raw     (io_in[g]),
      .filter_cnt (io_filterCnt),
      .en         (io_chEn[g]),
      .out        (io_out[g]),
      .rise       (io_rise[g]),
      .fall       (io_fall[g])
    );
  end

  // Pulses are already registered, so the OR is visible in the same cycle.
  assign io_changed = |(io_rise | io_fall);

`ifdef FILTER_IRQ_EN

  logic [CHANNELS-1:0] evt_q, evt_d;
  logic                irq_q, irq_d;

  // Sticky events: an edge pulse sets the bit and wins over a same-cycle clear.
  always_comb begin
    evt_d = (evt_q & ~io_evtClr) | io_rise | io_fall;
    irq_d = |evt_q;
  end

  // Event and interrupt registers with synchronous active-high reset.
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      evt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      evt_q <= evt_d;
      irq_q <= irq_d;
    end
  end

  assign io_evt = evt_q;
  assign io_irq = irq_q;

`else

  // Feature absent: keep the ports but drive constants and sink the clear.
  logic evt_clr_unused;
  assign evt_clr_unused = ^io_evtClr;
  assign io_evt         = '0;
  assign io_irq         = 1'b0;

`endif

endmodule

// File: tb/tb_multi_filter.sv
// tb_multi_filter: scoreboard bench for multi_filter. A timestamp-based
// reference model predicts every output each cycle; a monitor compares.
// Directed latency checks use the closed-form edge counts on top of that.
module tb_multi_filter;
  import filter_pkg::*;

  localparam int CH = DEF_CHANNELS;
  localparam int CW = DEF_CNT_WIDTH;
  localparam int SS = DEF_SYNC_STAGES;

  logic          io_clk = 1'b0;
  logic          io_rst;
  logic [CH-1:0] io_in;
  logic [CW-1:0] io_filterCnt;
  logic [CH-1:0] io_chEn;
  logic [CH-1:0] io_out;
  logic [CH-1:0] io_rise;
  logic [CH-1:0] io_fall;
  logic          io_changed;
  logic [CH-1:0] io_evtClr;
  logic [CH-1:0] io_evt;
  logic          io_irq;

  multi_filter #(
    .CHANNELS    (CH),
    .CNT_WIDTH   (CW),
    .SYNC_STAGES (SS)
  ) dut (
    .io_clk       (io_clk),
    .io_rst       (io_rst),
    .io_in        (io_in),
    .io_filterCnt (io_filterCnt),
    .io_chEn      (io_chEn),
    .io_out       (io_out),
    .io_rise      (io_rise),
    .io_fall      (io_fall),
    .io_changed   (io_changed),
    .io_evtClr    (io_evtClr),
    .io_evt       (io_evt),
    .io_irq       (io_irq)
  );

  always #5 io_clk = ~io_clk;

  typedef struct packed {
    logic [CH-1:0] out;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] evt;
    logic          changed;
    logic          irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Stimulus values applied on the next step.
  logic          rst_v;
  logic [CH-1:0] in_v;
  logic [CW-1:0] f_v;
  logic [CH-1:0] en_v;
  logic [CH-1:0] clr_v;

  // Reference model: the synchroniser is a plain delay line of input vectors,
  // and each channel's counter is a "stable-from" deadline timestamp.
  logic [CH-1:0] m_hist[$];
  longint        m_dl[CH];
  longint        now = 0;
  logic [CH-1:0] m_d    = '0;
  logic [CH-1:0] m_out  = '0;
  logic [CH-1:0] m_rise = '0;
  logic [CH-1:0] m_fall = '0;
  logic [CH-1:0] m_evt  = '0;
  logic          m_irq  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Apply one cycle of stimulus, predict the post-edge outputs, queue them.
  task automatic step();
    exp_t          e;
    logic [CH-1:0] s;
    logic [CH-1:0] out_n, rise_n, fall_n, evt_n;
    logic          irq_n;
    longint        r;
    @(negedge io_clk);
    io_rst       = rst_v;
    io_in        = in_v;
    io_filterCnt = f_v;
    io_chEn      = en_v;
    io_evtClr    = clr_v;
    now++;
    r = (f_v == '0) ? 64'd0 : longint'(f_v) - 1;
    if (rst_v) begin
      m_hist.delete();
      repeat (SS) m_hist.push_back('0);
      for (int c = 0; c < CH; c++) m_dl[c] = now;
      m_d    = '0;
      out_n  = '0;
      rise_n = '0;
      fall_n = '0;
      evt_n  = '0;
      irq_n  = 1'b0;
    end else begin
      s = m_hist.pop_front();
      m_hist.push_back(in_v);
      for (int c = 0; c < CH; c++) begin
        if (en_v[c]) begin
          // Stable long enough once the deadline lies strictly in the past.
          out_n[c] = (now > m_dl[c]) ? m_d[c] : m_out[c];
          if (s[c] != m_d[c]) m_dl[c] = now + r;
        end else begin
          out_n[c] = m_out[c];
          m_dl[c]  = now + r;
        end
      end
      m_d    = s;
      rise_n = out_n & ~m_out;
      fall_n = ~out_n & m_out;
`ifdef FILTER_IRQ_EN
      evt_n = (m_evt & ~clr_v) | m_rise | m_fall;
      irq_n = |m_evt;
`else
      evt_n = '0;
      irq_n = 1'b0;
`endif
    end
    m_out  = out_n;
    m_rise = rise_n;
    m_fall = fall_n;
    m_evt  = evt_n;
    m_irq  = irq_n;
    e.out     = out_n;
    e.rise    = rise_n;
    e.fall    = fall_n;
    e.evt     = evt_n;
    e.changed = |(rise_n | fall_n);
    e.irq     = irq_n;
    exp_q.push_back(e);
    @(posedge io_clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Drive a level onto one channel and count steps (sampling edge = 1) until
  // io_out shows it; 101 means it never arrived within the budget.
  task automatic measure(input int ch, input logic val, input int chg_at,
                         input logic [CW-1:0] f_new, output int k);
    k = 101;
    in_v[ch] = val;
    for (int i = 1; i <= 100; i++) begin
      if (i == chg_at) f_v = f_new;
      step();
      if (io_out[ch] == val) begin
        k = i;
        break;
      end
    end
  endtask

  // Monitor: compare every presented output against the queued prediction.
  always @(posedge io_clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_out",     64'(io_out),     64'(e.out));
      check("sb_rise",    64'(io_rise),    64'(e.rise));
      check("sb_fall",    64'(io_fall),    64'(e.fall));
      check("sb_changed", 64'(io_changed), 64'(e.changed));
      check("sb_evt",     64'(io_evt),     64'(e.evt));
      check("sb_irq",     64'(io_irq),     64'(e.irq));
    end
  end

  initial begin
    int k;
    int pulses;
    int rises;
    int falls;
    logic frozen;
    int fs[6] = '{0, 1, 2, 3, 5, 8};

    // Reset with all inputs high and F=4.
    rst_v = 1'b1;
    in_v  = '1;
    f_v   = 32'd4;
    en_v  = '1;
    clr_v = '0;
    idle(3);
    check("reset_out", 64'(io_out), 64'd0);
    rst_v = 1'b0;
    k = 21;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (io_out == '1) begin
        k = i;
        break;
      end
    end
    check("reset_latency", 64'(k), 64'(SS + 4 + 1));
    check("reset_rise", 64'(io_rise), 64'hFF);
    check("reset_changed", 64'(io_changed), 64'd1);
    step();
    check("reset_rise_width", 64'(io_rise), 64'd0);

    // Settle everything low.
    in_v = '0;
    idle(12);

    // Glitch rejection on channel 0 with F=10.
    f_v = 32'd10;
    idle(3);
    pulses = 0;
    in_v[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 6) in_v[0] = 1'b0;
      step();
      pulses += int'(io_out[0]) + int'(io_rise[0]) + int'(io_fall[0]);
    end
    check("glitch_6_reject", 64'(pulses), 64'd0);
    rises = 0;
    falls = 0;
    in_v[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 12) in_v[0] = 1'b0;
      step();
      rises += int'(io_rise[0]);
      falls += int'(io_fall[0]);
    end
    check("pulse_12_rise", 64'(rises), 64'd1);
    check("pulse_12_fall", 64'(falls), 64'd1);

    // F=0 behaves like F=1 on channel 3.
    f_v = 32'd0;
    idle(3);
    measure(3, 1'b1, 0, '0, k);
    check("f0_latency", 64'(k), 64'(SS + 1 + 1));
    idle(6);
    f_v = 32'd1;
    idle(3);
    measure(3, 1'b0, 0, '0, k);
    check("f1_latency", 64'(k), 64'(SS + 1 + 1));
    idle(6);

    // Mid-count filter change on channel 1.
    f_v = 32'd20;
    idle(3);
    measure(1, 1'b1, 6, 32'd2, k);
    check("midcount_latency", 64'(k), 64'(SS + 20 + 1));
    check("midcount_rise", 64'(io_rise[1]), 64'd1);
    idle(4);
    measure(1, 1'b0, 0, '0, k);
    check("newcount_latency", 64'(k), 64'(SS + 2 + 1));
    idle(4);

    // Disable channel 2, toggle its input, then re-enable with F=3.
    f_v = 32'd3;
    in_v[2] = 1'b0;
    idle(8);
    en_v[2] = 1'b0;
    frozen = io_out[2];
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 6 && (i % 2) == 0) in_v[2] = ~in_v[2];
      step();
      if (io_out[2] != frozen) pulses++;
      pulses += int'(io_rise[2]) + int'(io_fall[2]);
    end
    check("disable_frozen", 64'(pulses), 64'd0);
    en_v[2] = 1'b1;
    k = 21;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (io_out[2] == 1'b1) begin
        k = i;
        break;
      end
    end
    check("reenable_latency", 64'(k), 64'd3);
    check("reenable_rise", 64'(io_rise[2]), 64'd1);
    step();
    check("reenable_rise_width", 64'(io_rise[2]), 64'd0);
    idle(4);

`ifdef FILTER_IRQ_EN
    // Sticky event and interrupt on channel 5.
    f_v   = 32'd2;
    clr_v = '1;
    idle(3);
    clr_v = 8'hDF;
    idle(2);
    measure(5, 1'b1, 0, '0, k);
    check("irq_rise_seen", 64'(io_rise[5]), 64'd1);
    step();
    check("evt_set", 64'(io_evt[5]), 64'd1);
    check("irq_lag", 64'(io_irq), 64'd0);
    step();
    check("irq_set", 64'(io_irq), 64'd1);
    measure(5, 1'b0, 0, '0, k);
    check("irq_fall_seen", 64'(io_fall[5]), 64'd1);
    clr_v[5] = 1'b1;
    step();
    check("evt_set_wins", 64'(io_evt[5]), 64'd1);
    step();
    check("evt_cleared", 64'(io_evt[5]), 64'd0);
    check("irq_still_set", 64'(io_irq), 64'd1);
    clr_v = '0;
    step();
    check("irq_cleared", 64'(io_irq), 64'd0);
`endif

    // Randomised traffic on all channels.
    clr_v = '0;
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) in_v[c] = ~in_v[c];
        if ($urandom_range(0, 60) == 0) en_v[c] = ~en_v[c];
      end
      if ($urandom_range(0, 40) == 0) f_v = 32'(fs[$urandom_range(0, 5)]);
      clr_v = CH'($urandom) & CH'($urandom);
      rst_v = ($urandom_range(0, 999) == 0);
      step();
    end
    rst_v = 1'b0;
    clr_v = '0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_filter.md
Name: multi_filter

Overview:
- N-channel glitch filter / debouncer. Each input is synchronised, then qualified by a stability counter; the output changes only after the synchronised input has been stable for io_filterCnt cycles.
- Adds per-channel enable, registered rise/fall pulses and an aggregate change flag.
- Sits between raw board/asynchronous inputs (buttons, status lines, trigger pins) and control logic in the io_clk domain.

Parameters:
- CHANNELS, 8: number of independent filter channels (≥1).
- CNT_WIDTH, 32: width of the filter count and of each per-channel counter.
- SYNC_STAGES, 2: synchroniser flops per input (≥1).

Ports:
- io_clk  in  1  sole clock.
- io_rst  in  1  synchronous reset, active-high.
- io_in  in  CHANNELS  raw asynchronous inputs.
- io_filterCnt  in  CNT_WIDTH  required stable cycles, shared by all channels; sampled only at counter reload.
- io_chEn  in  CHANNELS  per-channel enable; 0 freezes that channel's output.
- io_out  out  CHANNELS  filtered levels.
- io_rise  out  CHANNELS  1-cycle pulse when io_out[i] goes 0->1.
- io_fall  out  CHANNELS  1-cycle pulse when io_out[i] goes 1->0.
- io_changed  out  1  OR of io_rise | io_fall, in the same cycle.
- io_evtClr  in  CHANNELS  write-one-to-clear for sticky events (FILTER_IRQ_EN).
- io_evt  out  CHANNELS  sticky event bits (FILTER_IRQ_EN).
- io_irq  out  1  registered OR of io_evt (FILTER_IRQ_EN).

Behaviour:
- Reset (io_rst=1 at an edge) clears all of the following to 0: sync flops, d, cnt, io_out, io_rise, io_fall, io_changed, io_evt and io_irq.
- Per channel i, s is the last sync stage, d is s delayed by one cycle, and cnt is CNT_WIDTH bits wide.
- Reload value R = (io_filterCnt==0) ? 0 : io_filterCnt-1. A filter count of 0 behaves exactly like 1; there is no wrap to all-ones.
- Enabled update, in priority order:
  - If s != d, cnt <= R.
  - Else if cnt != 0, cnt <= cnt-1.
  - Else cnt holds.
  - In all cases, d <= s.
  - io_out[i] <= (cnt==0) ? d : io_out[i].
- Disabled (io_chEn[i]=0):
  - cnt <= R every cycle; io_out[i] holds; sync flops and d keep running.
  - After re-enable, io_out updates only once the input has been stable for a full R+1 count. No immediate edge.
- Latency: a clean input step reaches io_out exactly SYNC_STAGES + max(F,1) + 1 clock edges after its first sampling edge, where F is io_filterCnt.
- Rejection: a pulse whose synchronised width is shorter than max(F,1) cycles never reaches io_out. On return to the old level the counter reloads and the old value is re-latched, so no edge is produced.
- io_rise[i]/io_fall[i] are registered. They assert in the same cycle the new io_out value is visible, for exactly 1 cycle, and are 0 during reset and while the channel is disabled.
- Changing io_filterCnt mid-count does not affect in-flight counts; the new value applies at the next reload.
- Channels are fully independent. Simultaneous edges on several channels are all reported in the same cycle.

Optional Feature:
- Macro: FILTER_IRQ_EN.
- Defined:
  - io_evt[i] sets on io_rise[i]|io_fall[i]. It clears on io_evtClr[i]=1; set wins over clear in the same cycle.
  - io_irq <= |io_evt, so it lags io_evt by 1 cycle.
- Undefined: ports remain present; io_evt and io_irq are tied 0 and io_evtClr is ignored.

Decomposition:
- Package filter_pkg holds:
  - Default-parameter localparams.
  - A function computing R from a count, including the 0 -> 0 saturation.
- Sub-module filter_chan holds one channel: sync chain, d, cnt, out, rise and fall. It is instantiated CHANNELS times via generate.
- The top-level holds io_changed and the FILTER_IRQ_EN event/irq logic.

Test Plan:
- Reset with io_in=8'hFF, F=4, all enabled: io_out=0 during reset. io_out=8'hFF and io_rise=8'hFF for 1 cycle exactly 7 edges after reset release (SYNC_STAGES 2 + F 4 + 1); io_changed=1 in the same cycle.
- Glitch: F=10, io_in[0] pulses high for 6 cycles: io_out[0] stays 0 and io_rise/io_fall stay 0. A 12-cycle pulse produces a rise then a fall, each as a 1-cycle pulse.
- F=0 vs F=1: a step on channel 3 reaches io_out after 4 edges in both cases, with no counter wrap.
- Mid-count change: step channel 1 with F=20, then after 5 cycles write F=2: the output still updates at 23 edges. The next step uses F=2 (5 edges).
- Disable: io_chEn[2]=0, toggle io_in[2] and hold: io_out[2] frozen, no pulses. Re-enable with F=3: the update occurs 3 cycles after enable, with a single rise.
- FILTER_IRQ_EN: a rise on channel 5 sets io_evt[5], and io_irq follows 1 cycle later. io_evtClr[5] in the same cycle as a new fall keeps the bit set; a clear alone drops io_evt[5], and io_irq drops 1 cycle later.
